// File: rtl/io_board_responder.sv
// rtl/io_board_responder.sv - bus-addressed I/O board: debounced input read port, latched output write port
// All host-side signals are synchronized before use; the bus is driven only from READ.
module io_board_responder #(
  parameter logic [3:0] BOARD_ID        = 4'd0,
  parameter logic [7:0] DEBOUNCE_CYCLES = 8'd4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] io_address,
  input  logic [1:0] io_enable_n,
  inout  wire  [7:0] io_data,
  input  logic [7:0] board_inputs,
  output logic [7:0] board_outputs,
  output logic       write_strobe,
  output logic       bus_error
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERROR} state_t;

  state_t      state, next_state;
  logic [3:0]  addr_s1, addr_s2;
  logic [1:0]  en_s1, en_s2;
  logic [7:0]  data_s1, data_s2;
  logic [7:0]  in_s1, in_s2;
  logic [1:0]  valid_sr;
  logic        armed;
  logic [7:0]  in_last;
  logic [7:0]  debounced;
  logic [7:0]  cnt [8];
  logic [7:0]  read_value;
  logic        drive_en;
  logic        rd_s, wr_s, both_low, selected;
  logic        enter_read, enter_write, enter_error, oe;

  // Strobe synchronizers reset to the inactive level so reset never looks like a strobe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_s1  <= 4'd0;
      addr_s2  <= 4'd0;
      en_s1    <= 2'b11;
      en_s2    <= 2'b11;
      data_s1  <= 8'd0;
      data_s2  <= 8'd0;
      in_s1    <= 8'd0;
      in_s2    <= 8'd0;
      valid_sr <= 2'b00;
      armed    <= 1'b0;
    end else begin
      addr_s1  <= io_address;
      addr_s2  <= addr_s1;
      en_s1    <= io_enable_n;
      en_s2    <= en_s1;
      data_s1  <= io_data;
      data_s2  <= data_s1;
      in_s1    <= board_inputs;
      in_s2    <= in_s1;
      valid_sr <= {valid_sr[0], 1'b1};
      // Only real post-reset samples of both strobes high may arm the FSM.
      if (valid_sr[1] && en_s2 == 2'b11)
        armed <= 1'b1;
    end
  end

  assign rd_s     = en_s2[0];
  assign wr_s     = en_s2[1];
  assign both_low = !rd_s && !wr_s;
  assign selected = (addr_s2 == BOARD_ID);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_last   <= 8'd0;
      debounced <= 8'd0;
      for (int i = 0; i < 8; i++)
        cnt[i] <= 8'd0;
    end else begin
      in_last <= in_s2;
      for (int i = 0; i < 8; i++) begin
        if (in_s2[i] != in_last[i])
          cnt[i] <= 8'd0;
        else if (cnt[i] != 8'hFF)
          cnt[i] <= cnt[i] + 8'd1;
        if (cnt[i] >= DEBOUNCE_CYCLES)
          debounced[i] <= in_last[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (armed && selected) begin
          if (both_low)
            next_state = ERROR;
          else if (!rd_s)
            next_state = READ;
          else if (!wr_s)
            next_state = WRITE;
        end
      end
      READ: begin
        if (both_low)
          next_state = ERROR;
        else if (rd_s || !selected)
          next_state = IDLE;
      end
      WRITE: begin
        if (both_low)
          next_state = ERROR;
        else if (wr_s)
          next_state = IDLE;
      end
      ERROR: begin
        if (rd_s && wr_s)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output gating on wr_s releases the bus in the very cycle a write strobe is seen.
  always_comb begin
    enter_read  = (state == IDLE) && (next_state == READ);
    enter_write = (state == IDLE) && (next_state == WRITE);
    enter_error = (state != ERROR) && (next_state == ERROR);
    oe          = drive_en && (state == READ) && wr_s;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      drive_en      <= 1'b0;
      read_value    <= 8'd0;
      board_outputs <= 8'd0;
      write_strobe  <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      drive_en     <= (state == READ) && (next_state == READ);
      write_strobe <= enter_write;
      if (enter_read)
        read_value <= debounced;
      if (enter_write)
        board_outputs <= data_s2;
      if (enter_error)
        bus_error <= 1'b1;
    end
  end

  assign io_data = oe ? read_value : 8'hzz;

endmodule
